// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  localparam int          REG_AW    = 5;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN         = 2'd0,
    MEM_WAIT    = 2'd1,
    ERR_RECOVER = 2'd2
  } state_e;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Free-running hazard performance counters; all wrap modulo 2^CNT_W.
module hazard_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_any,
  input  logic             load_use,
  input  logic             flush_e,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] load_use_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Event counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= {CNT_W{1'b0}};
      load_use_cnt <= {CNT_W{1'b0}};
      flush_cnt    <= {CNT_W{1'b0}};
    end else begin
      stall_cycles <= stall_any ? stall_cycles + CNT_W'(1) : stall_cycles;
      load_use_cnt <= load_use  ? load_use_cnt + CNT_W'(1) : load_use_cnt;
      flush_cnt    <= flush_e   ? flush_cnt + CNT_W'(1)    : flush_cnt;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes, memory-wait FSM.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
  parameter int REG_AW  = hazard_pkg::REG_AW,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] RdE,
  input  logic              LoadE,
  input  logic              PCSrcE,
  input  logic              MemBusyM,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              MemErr,
  output logic              Waiting
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  StallCycles,
  output logic [CNT_W-1:0]  LoadUseCnt,
  output logic [CNT_W-1:0]  FlushCnt
`endif
);
  import hazard_pkg::*;

  localparam int              WCW     = $clog2(TIMEOUT + 1);
  localparam logic [WCW-1:0]  WC_LAST = WCW'(TIMEOUT - 1);
  localparam logic [WCW-1:0]  WC_MAX  = {WCW{1'b1}};

  if (CNT_W < 1 || TIMEOUT < 2) begin : g_bad_params
    $error("hazard_ctrl: CNT_W must be >= 1 and TIMEOUT >= 2");
  end

  state_e         state_r;
  state_e         state_nxt_s;
  logic [WCW-1:0] wait_cnt_r;
  logic           mem_err_r;
  logic           load_use_s;
  logic [5:0]     ctl_s;   // {StallF, StallD, StallE, StallM, FlushD, FlushE}

  assign load_use_s = LoadE && (RdE != {REG_AW{1'b0}}) && ((RdE == Rs1D) || (RdE == Rs2D));

  // Next-state logic; a ready memory beats the timeout on the final wait cycle
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      RUN: begin
        if (MemBusyM) state_nxt_s = MEM_WAIT;
        else          state_nxt_s = RUN;
      end
      MEM_WAIT: begin
        if (!MemBusyM)                 state_nxt_s = RUN;
        else if (wait_cnt_r == WC_LAST) state_nxt_s = ERR_RECOVER;
        else                           state_nxt_s = MEM_WAIT;
      end
      ERR_RECOVER: state_nxt_s = RUN;
      default:     state_nxt_s = RUN;
    endcase
  end

  // State, saturating wait counter and sticky error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= RUN;
      wait_cnt_r <= {WCW{1'b0}};
      mem_err_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (state_r != MEM_WAIT)     wait_cnt_r <= {WCW{1'b0}};
      else if (wait_cnt_r != WC_MAX) wait_cnt_r <= wait_cnt_r + WCW'(1);
      else                         wait_cnt_r <= wait_cnt_r;
      if (state_nxt_s == ERR_RECOVER) mem_err_r <= 1'b1;
      else                            mem_err_r <= mem_err_r;
    end
  end

  // Stall/flush decode; recovery flushes the abandoned access even if busy persists
  always_comb begin
    ctl_s = 6'b00_0000;
    if (!rst_n)                       ctl_s = 6'b00_0000;
    else if (state_r == ERR_RECOVER)  ctl_s = 6'b00_0011;
    else if (MemBusyM)                ctl_s = 6'b11_1100;
    else if (PCSrcE)                  ctl_s = 6'b00_0011;
    else if (load_use_s)              ctl_s = 6'b11_0001;
    else                              ctl_s = 6'b00_0000;
  end

  assign {StallF, StallD, StallE, StallM, FlushD, FlushE} = ctl_s;
  assign MemErr  = mem_err_r;
  assign Waiting = (state_r == MEM_WAIT);

`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_cnt #(
    .CNT_W(CNT_W)
  ) u_perf_cnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall_any   (StallF | StallD | StallE | StallM),
    .load_use    (StallD & ~StallE),
    .flush_e     (FlushE),
    .stall_cycles(StallCycles),
    .load_use_cnt(LoadUseCnt),
    .flush_cnt   (FlushCnt)
  );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (TIMEOUT overridden to 4).
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] Rs1D, Rs2D, RdE;
  logic       LoadE, PCSrcE, MemBusyM;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, MemErr, Waiting;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] StallCycles, LoadUseCnt, FlushCnt;
`endif
  logic [7:0] outs;
  int         n_checks = 0;
  int         n_pass   = 0;

  assign outs = {StallF, StallD, StallE, StallM, FlushD, FlushE, Waiting, MemErr};

  always #5 clk = ~clk;

  hazard_ctrl #(
    .REG_AW (5),
    .CNT_W  (32),
    .TIMEOUT(4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .Rs1D    (Rs1D),
    .Rs2D    (Rs2D),
    .RdE     (RdE),
    .LoadE   (LoadE),
    .PCSrcE  (PCSrcE),
    .MemBusyM(MemBusyM),
    .StallF  (StallF),
    .StallD  (StallD),
    .StallE  (StallE),
    .StallM  (StallM),
    .FlushD  (FlushD),
    .FlushE  (FlushE),
    .MemErr  (MemErr),
    .Waiting (Waiting)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .StallCycles(StallCycles),
    .LoadUseCnt (LoadUseCnt),
    .FlushCnt   (FlushCnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
  endtask

  // One cycle: drive at posedge+1, check outputs {SF,SD,SE,SM,FD,FE,W,Err} at negedge
  task automatic vec(input string tag, input logic ld, input logic [4:0] rd,
                     input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic pc, input logic busy, input logic [7:0] exp_v);
    LoadE = ld; RdE = rd; Rs1D = rs1; Rs2D = rs2; PCSrcE = pc; MemBusyM = busy;
    @(negedge clk);
    chk(tag, {24'd0, outs}, {24'd0, exp_v});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; LoadE = 1'b0; PCSrcE = 1'b0; MemBusyM = 1'b1;
    RdE = 5'd0; Rs1D = 5'd0; Rs2D = 5'd0;
    #2;
    chk("reset_outs", {24'd0, outs}, 32'd0);
    MemBusyM = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    vec("idle",         1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 8'b0000_0000);
    vec("lu_rs1",       1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 8'b1100_0100);
    vec("lu_one_cycle", 1'b0, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 8'b0000_0000);
    vec("lu_rs2",       1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 8'b1100_0100);
    vec("rd_zero",      1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 8'b0000_0000);
    vec("no_match",     1'b1, 5'd5, 5'd6, 5'd4, 1'b0, 1'b0, 8'b0000_0000);
    vec("branch_lu",    1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 8'b0000_1100);
    vec("branch",       1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 8'b0000_1100);

    // Three busy cycles with hazards pending, then release
    vec("busy1",        1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1, 8'b1111_0000);
    vec("busy2",        1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 8'b1111_0010);
    vec("busy3",        1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 8'b1111_0010);
    vec("busy_fall",    1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 8'b0000_0010);
`ifdef HAZARD_PERF_CNT_EN
    chk("load_use_cnt", LoadUseCnt, 32'd2);
    chk("stall_cycles", StallCycles, 32'd5);
    chk("flush_cnt",    FlushCnt, 32'd4);
`endif
    vec("back_run",     1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 8'b0000_0000);

    // Load-use pending when the memory becomes ready applies in that cycle
    vec("busy_lu",      1'b1, 5'd9, 5'd0, 5'd9, 1'b0, 1'b1, 8'b1111_0000);
    vec("fall_lu",      1'b1, 5'd9, 5'd0, 5'd9, 1'b0, 1'b0, 8'b1100_0110);
    vec("after_fall",   1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 8'b0000_0000);

    // Timeout: one RUN busy cycle, four MEM_WAIT cycles, then recovery
    vec("to_enter",     1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 8'b1111_0000);
    for (int i = 0; i < 4; i++)
      vec("to_wait",    1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 8'b1111_0010);
    vec("to_recover",   1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 8'b0000_1101);
    vec("err_sticky",   1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 8'b1100_0101);
    vec("err_sticky2",  1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 8'b0000_0001);

    // Reset in the middle of a memory wait
    vec("rw_enter",     1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 8'b1111_0001);
    vec("rw_wait",      1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 8'b1111_0011);
    rst_n = 1'b0;
    #1;
    chk("rst_async", {24'd0, outs}, 32'd0);
`ifdef HAZARD_PERF_CNT_EN
    chk("rst_stall_cycles", StallCycles, 32'd0);
    chk("rst_load_use_cnt", LoadUseCnt, 32'd0);
`endif
    @(posedge clk);
    #1;
    MemBusyM = 1'b0;
    rst_n = 1'b1;
    vec("post_rst",     1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 8'b0000_0000);
    vec("post_rst_lu",  1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 8'b1100_0100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
